rf_wb_arbiter: RTL and testbench

Writeback arbiter and scheduler for the single register-file write port. It accepts writeback requests from NREQ execution sources over valid/ready handshakes and grants one per cycle in round-robin order. The granted result is registered into a one-entry writeback stage that drives the register file's write port. While a result waits in that stage, the block forwards it to the two combinational read ports so reads never observe stale data.

---
 rtl/rf_wb_arbiter_pkg.sv | 28 ++
 rtl/rf_wb_arbiter_rr_pick.sv | 33 +++
 rtl/rf_wb_arbiter.sv | 103 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared defaults and helpers for the register-file writeback arbiter.
// Defaults follow the codebase-wide param.v macros when they are defined.
`ifndef RF_SIZE_LOG
`define RF_SIZE_LOG 5
`endif
`ifndef REG_LEN
`define REG_LEN 32
`endif
`ifndef WB_NREQ
`define WB_NREQ 3
`endif

package rf_wb_arbiter_pkg;

    localparam int unsigned WB_NREQ_DEF     = `WB_NREQ;
    localparam int unsigned RF_SIZE_LOG_DEF = `RF_SIZE_LOG;
    localparam int unsigned REG_LEN_DEF     = `REG_LEN;

    // Pointer width; kept at least 1 so the single-requester build still has a register.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_pick.sv
// Combinational round-robin priority picker: first set request at or after ptr,
// wrapping modulo NREQ; returns a one-hot grant and its binary index.
module rr_pick
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = WB_NREQ_DEF,
    parameter int unsigned PTR_W = ptr_width(WB_NREQ_DEF)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [PTR_W-1:0] idx_o
);

    logic [PTR_W-1:0] j;
    logic             found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = PTR_W'((32'(ptr_i) + k) % NREQ);
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the single register-file write port: round-robin grant,
// one-entry registered writeback stage, and forwarding onto both read ports.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned NREQ        = WB_NREQ_DEF,
    parameter int unsigned RF_SIZE_LOG = RF_SIZE_LOG_DEF,
    parameter int unsigned REG_LEN     = REG_LEN_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*RF_SIZE_LOG-1:0] req_rd,
    input  logic [NREQ*REG_LEN-1:0]     req_data,
    input  logic                        hold,
    output logic                        rf_wen,
    output logic [RF_SIZE_LOG-1:0]      rf_rd,
    output logic [REG_LEN-1:0]          rf_rd_data,
    input  logic [RF_SIZE_LOG-1:0]      rs1,
    input  logic [RF_SIZE_LOG-1:0]      rs2,
    input  logic [REG_LEN-1:0]          rs1_rf_data,
    input  logic [REG_LEN-1:0]          rs2_rf_data,
    output logic [REG_LEN-1:0]          rs1_data,
    output logic [REG_LEN-1:0]          rs2_data
);

    localparam int unsigned PTR_W = ptr_width(NREQ);

    logic [PTR_W-1:0]       ptr_q, ptr_d, pick_idx;
    logic [NREQ-1:0]        pick_gnt;
    logic                   grant_any;
    logic                   wb_valid_q;
    logic [RF_SIZE_LOG-1:0] wb_rd_q, sel_rd;
    logic [REG_LEN-1:0]     wb_data_q, sel_data;

    rr_pick #(
        .NREQ (NREQ),
        .PTR_W(PTR_W)
    ) u_pick (
        .req_i(req_valid),
        .ptr_i(ptr_q),
        .gnt_o(pick_gnt),
        .idx_o(pick_idx)
    );

    // The stage drains every cycle, so only hold can block a grant.
    assign req_ready = hold ? '0 : pick_gnt;
    assign grant_any = |req_ready;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                sel_rd   = req_rd[i*RF_SIZE_LOG +: RF_SIZE_LOG];
                sel_data = req_data[i*REG_LEN +: REG_LEN];
            end
        end
    end

    assign ptr_d = grant_any ? PTR_W'(rr_next(32'(pick_idx), NREQ)) : ptr_q;

    // Reset flushes the stage; a write granted in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wb_valid_q <= grant_any;
            if (grant_any) begin
                wb_rd_q   <= sel_rd;
                wb_data_q <= sel_data;
            end
        end
    end

    assign rf_wen     = wb_valid_q && (wb_rd_q != '0);
    assign rf_rd      = wb_rd_q;
    assign rf_rd_data = wb_data_q;

    always_comb begin
        if (rs1 == '0)
            rs1_data = '0;
        else if (wb_valid_q && wb_rd_q == rs1)
            rs1_data = wb_data_q;
        else
            rs1_data = rs1_rf_data;
    end

    always_comb begin
        if (rs2 == '0)
            rs2_data = '0;
        else if (wb_valid_q && wb_rd_q == rs2)
            rs2_data = wb_data_q;
        else
            rs2_data = rs2_rf_data;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed vector bench for rf_wb_arbiter (NREQ=3, 5-bit indices, 32-bit data).
module tb_rf_wb_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned RW = 5;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*RW-1:0] req_rd;
    logic [N*DW-1:0] req_data;
    logic            hold;
    logic            rf_wen;
    logic [RW-1:0]   rf_rd, rs1, rs2;
    logic [DW-1:0]   rf_rd_data, rs1_rf_data, rs2_rf_data, rs1_data, rs2_data;

    rf_wb_arbiter #(.NREQ(N), .RF_SIZE_LOG(RW), .REG_LEN(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rd(req_rd), .req_data(req_data), .hold(hold),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_rd_data(rf_rd_data),
        .rs1(rs1), .rs2(rs2),
        .rs1_rf_data(rs1_rf_data), .rs2_rf_data(rs2_rf_data),
        .rs1_data(rs1_data), .rs2_data(rs2_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    valid;
        logic            hold;
        logic [N*RW-1:0] rd;
        logic [N*DW-1:0] data;
        logic [RW-1:0]   rs1;
        logic [DW-1:0]   rs1_rf;
        logic [RW-1:0]   rs2;
        logic [DW-1:0]   rs2_rf;
        logic [N-1:0]    e_ready;
        logic            e_wen;
        logic [RW-1:0]   e_rfrd;
        logic [DW-1:0]   e_rfdata;
        logic [DW-1:0]   e_rs1;
        logic [DW-1:0]   e_rs2;
        logic [1:0]      e_ptr;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    localparam logic [N*RW-1:0] RD_F  = {5'd3, 5'd2, 5'd1};
    localparam logic [N*DW-1:0] DAT_F = {32'hA2, 32'hA1, 32'hA0};
    localparam logic [N*RW-1:0] RD_9  = {5'd9, 5'd9, 5'd9};
    localparam logic [N*DW-1:0] DAT_C = {32'hC2, 32'hC1, 32'hC0};

    vec_t vec[22];

    initial begin
        // valid hold rd data | rs1 rs1_rf rs2 rs2_rf | ready wen rfrd rfdata rs1 rs2 ptr
        vec[0]  = '{3'b001, 1'b0, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'hDEADBEEF},
                    5'd0, 32'h99, 5'd7, 32'h0, 3'b001, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 2'd0};
        vec[1]  = '{3'b000, 1'b0, RD_F, DAT_F, 5'd5, 32'h11, 5'd7, 32'h0,
                    3'b000, 1'b1, 5'd7, 32'hDEADBEEF, 32'h11, 32'hDEADBEEF, 2'd1};
        vec[2]  = '{3'b100, 1'b0, RD_F, DAT_F, 5'd3, 32'h33, 5'd7, 32'h5,
                    3'b100, 1'b0, 5'd7, 32'hDEADBEEF, 32'h33, 32'h5, 2'd1};
        vec[3]  = '{3'b111, 1'b0, RD_F, DAT_F, 5'd1, 32'h77, 5'd0, 32'h88,
                    3'b001, 1'b1, 5'd3, 32'hA2, 32'h77, 32'h0, 2'd0};
        vec[4]  = '{3'b111, 1'b0, RD_F, DAT_F, 5'd1, 32'h77, 5'd0, 32'h88,
                    3'b010, 1'b1, 5'd1, 32'hA0, 32'hA0, 32'h0, 2'd1};
        vec[5]  = '{3'b111, 1'b0, RD_F, DAT_F, 5'd1, 32'h77, 5'd0, 32'h88,
                    3'b100, 1'b1, 5'd2, 32'hA1, 32'h77, 32'h0, 2'd2};
        vec[6]  = '{3'b111, 1'b0, RD_F, DAT_F, 5'd1, 32'h77, 5'd0, 32'h88,
                    3'b001, 1'b1, 5'd3, 32'hA2, 32'h77, 32'h0, 2'd0};
        vec[7]  = '{3'b111, 1'b0, RD_F, DAT_F, 5'd1, 32'h77, 5'd0, 32'h88,
                    3'b010, 1'b1, 5'd1, 32'hA0, 32'hA0, 32'h0, 2'd1};
        vec[8]  = '{3'b111, 1'b0, RD_F, DAT_F, 5'd1, 32'h77, 5'd0, 32'h88,
                    3'b100, 1'b1, 5'd2, 32'hA1, 32'h77, 32'h0, 2'd2};
        vec[9]  = '{3'b010, 1'b0, RD_F, DAT_F, 5'd2, 32'h22, 5'd0, 32'h88,
                    3'b010, 1'b1, 5'd3, 32'hA2, 32'h22, 32'h0, 2'd0};
        vec[10] = '{3'b010, 1'b0, RD_F, DAT_F, 5'd2, 32'h22, 5'd0, 32'h88,
                    3'b010, 1'b1, 5'd2, 32'hA1, 32'hA1, 32'h0, 2'd2};
        vec[11] = '{3'b011, 1'b0, RD_F, DAT_F, 5'd2, 32'h22, 5'd0, 32'h88,
                    3'b001, 1'b1, 5'd2, 32'hA1, 32'hA1, 32'h0, 2'd2};
        vec[12] = '{3'b011, 1'b0, RD_F, DAT_F, 5'd2, 32'h22, 5'd0, 32'h88,
                    3'b010, 1'b1, 5'd1, 32'hA0, 32'h22, 32'h0, 2'd1};
        vec[13] = '{3'b001, 1'b0, {5'd3, 5'd2, 5'd0}, {32'hA2, 32'hA1, 32'h55},
                    5'd0, 32'h44, 5'd2, 32'h9, 3'b001, 1'b1, 5'd2, 32'hA1, 32'h0, 32'hA1, 2'd2};
        vec[14] = '{3'b010, 1'b0, {5'd3, 5'd4, 5'd1}, {32'hA2, 32'h66, 32'hA0},
                    5'd0, 32'h44, 5'd0, 32'h9, 3'b010, 1'b0, 5'd0, 32'h55, 32'h0, 32'h0, 2'd1};
        vec[15] = '{3'b111, 1'b1, RD_F, DAT_F, 5'd0, 32'h44, 5'd4, 32'h0,
                    3'b000, 1'b1, 5'd4, 32'h66, 32'h0, 32'h66, 2'd2};
        vec[16] = '{3'b111, 1'b1, RD_F, DAT_F, 5'd0, 32'h44, 5'd4, 32'h1,
                    3'b000, 1'b0, 5'd4, 32'h66, 32'h0, 32'h1, 2'd2};
        vec[17] = '{3'b111, 1'b1, RD_F, DAT_F, 5'd0, 32'h44, 5'd4, 32'h1,
                    3'b000, 1'b0, 5'd4, 32'h66, 32'h0, 32'h1, 2'd2};
        vec[18] = '{3'b111, 1'b0, RD_F, DAT_F, 5'd0, 32'h44, 5'd4, 32'h1,
                    3'b100, 1'b0, 5'd4, 32'h66, 32'h0, 32'h1, 2'd2};
        vec[19] = '{3'b001, 1'b0, RD_9, DAT_C, 5'd9, 32'h5, 5'd0, 32'h0,
                    3'b001, 1'b1, 5'd3, 32'hA2, 32'h5, 32'h0, 2'd0};
        vec[20] = '{3'b010, 1'b0, RD_9, DAT_C, 5'd9, 32'h5, 5'd0, 32'h0,
                    3'b010, 1'b1, 5'd9, 32'hC0, 32'hC0, 32'h0, 2'd1};
        vec[21] = '{3'b000, 1'b0, RD_9, DAT_C, 5'd9, 32'h5, 5'd0, 32'h0,
                    3'b000, 1'b1, 5'd9, 32'hC1, 32'hC1, 32'h0, 2'd2};

        rst = 1'b1; hold = 1'b0; req_valid = '0; req_rd = '0; req_data = '0;
        rs1 = '0; rs2 = '0; rs1_rf_data = '0; rs2_rf_data = '0;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rs1 = 5'd5; rs1_rf_data = 32'h1234;
        @(negedge clk);
        check("idle_wen", 32'(rf_wen), 32'h0);
        check("idle_ready", 32'(req_ready), 32'h0);
        check("idle_rf_rd", 32'(rf_rd), 32'h0);
        check("idle_rf_data", rf_rd_data, 32'h0);
        check("idle_ptr", 32'(dut.ptr_q), 32'h0);
        check("idle_rs1_raw", rs1_data, 32'h1234);
        #1 rs1 = 5'd0;
        #1 check("idle_rs1_x0", rs1_data, 32'h0);

        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            req_valid = vec[i].valid; hold = vec[i].hold;
            req_rd = vec[i].rd; req_data = vec[i].data;
            rs1 = vec[i].rs1; rs1_rf_data = vec[i].rs1_rf;
            rs2 = vec[i].rs2; rs2_rf_data = vec[i].rs2_rf;
            @(negedge clk);
            check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vec[i].e_ready));
            check($sformatf("v%0d_wen", i), 32'(rf_wen), 32'(vec[i].e_wen));
            check($sformatf("v%0d_rf_rd", i), 32'(rf_rd), 32'(vec[i].e_rfrd));
            check($sformatf("v%0d_rf_data", i), rf_rd_data, vec[i].e_rfdata);
            check($sformatf("v%0d_rs1", i), rs1_data, vec[i].e_rs1);
            check($sformatf("v%0d_rs2", i), rs2_data, vec[i].e_rs2);
            check($sformatf("v%0d_ptr", i), 32'(dut.ptr_q), 32'(vec[i].e_ptr));
        end

        // Reset in the same cycle as a grant: the write is lost, ptr returns to 0
        @(posedge clk);
        #1;
        rst = 1'b1; hold = 1'b0;
        req_valid = 3'b001; req_rd = {5'd0, 5'd0, 5'd7}; req_data = {32'h0, 32'h0, 32'hDEADBEEF};
        rs1 = 5'd7; rs1_rf_data = 32'h3;
        @(negedge clk);
        check("rst_grant_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0; req_valid = '0;
        @(negedge clk);
        check("rst_wen", 32'(rf_wen), 32'h0);
        check("rst_ptr", 32'(dut.ptr_q), 32'h0);
        check("rst_rf_rd", 32'(rf_rd), 32'h0);
        check("rst_rf_data", rf_rd_data, 32'h0);
        check("rst_rs1_noforward", rs1_data, 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
